// File: rtl/p66b_pkg.sv
// Shared definitions for the 64b/66b PCS scrambling path.
// Holds sync-header codes, the idle control block, scrambler tap positions
// and a header-validity helper used by both TX and RX sides.
package p66b_pkg;

  localparam int unsigned BLOCK_W   = 66;
  localparam int unsigned PAYLOAD_W = 64;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  localparam logic [7:0]         BT_IDLE   = 8'h1E;
  localparam logic [BLOCK_W-1:0] P66B_IDLE = {56'h0, BT_IDLE, SYNC_CTRL};

  // Polynomial x^58 + x^39 + 1: taps are distances back in the scrambled stream.
  localparam int unsigned SCR_TAP_A = 39;
  localparam int unsigned SCR_TAP_B = 58;

  function automatic logic sync_hdr_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/p66b_scramble_comb.sv
// Single-cycle unrolled self-synchronous scrambler for one 64-bit payload.
// Ports:
//   state_i   - last 58 scrambled bits, state_i[57] most recent
//   payload_i - plain payload, bit 0 transmitted first
//   scr_o     - scrambled payload
//   state_o   - state after this payload (scr_o[63:6])
module p66b_scramble_comb
  import p66b_pkg::*;
(
  input  logic [SCR_TAP_B-1:0] state_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  output logic [PAYLOAD_W-1:0] scr_o,
  output logic [SCR_TAP_B-1:0] state_o
);

  always_comb begin
    // hist[57:0] is the incoming state, hist[58+i] is scrambled bit i, so the
    // bit k positions back from output i is always hist[58+i-k].
    logic [SCR_TAP_B+PAYLOAD_W-1:0] hist;
    hist = {{PAYLOAD_W{1'b0}}, state_i};
    for (int i = 0; i < int'(PAYLOAD_W); i++) begin
      hist[SCR_TAP_B+i] = payload_i[i]
                        ^ hist[SCR_TAP_B-SCR_TAP_A+i]
                        ^ hist[i];
    end
    scr_o   = hist[SCR_TAP_B +: PAYLOAD_W];
    state_o = hist[SCR_TAP_B+PAYLOAD_W-1 -: SCR_TAP_B];
  end

endmodule

// File: rtl/p66b_tx_scrambler.sv
// TX 64b/66b scrambler stage between the PCS encoder and the 66b->64b gearbox.
// Buffers one encoded block, scrambles its payload (x^58+x^39+1), passes the
// sync header through, and inserts scrambled idle blocks whenever the encoder
// has nothing ready, because the gearbox pulls a word on every ready cycle.
// Ports:
//   i_clk, i_reset - clock, synchronous active-high reset
//   S_VALID/S_READY/S_DATA - encoder-side block handshake ([1:0] sync header)
//   M_READY - gearbox consumes M_DATA on every cycle this is high
//   M_DATA  - registered scrambled block, always valid
//   o_idle  - pulse: word loaded on this edge is an inserted idle
//   o_err   - pulse: accepted block carried an invalid sync header
module p66b_tx_scrambler
  import p66b_pkg::*;
#(
  parameter bit                   OPT_SCRAMBLE = 1'b1,
  parameter logic [SCR_TAP_B-1:0] SEED         = 58'h3ff_ffff_ffff_ffff
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               S_VALID,
  output logic               S_READY,
  input  logic [BLOCK_W-1:0] S_DATA,
  input  logic               M_READY,
  output logic [BLOCK_W-1:0] M_DATA,
  output logic               o_idle,
  output logic               o_err
);

  logic [BLOCK_W-1:0]   hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [SCR_TAP_B-1:0] state_q, state_d;
  logic [BLOCK_W-1:0]   m_data_q, m_data_d;
  logic                 idle_q, idle_d;
  logic                 err_q, err_d;

  logic [BLOCK_W-1:0]   src_block;
  logic [PAYLOAD_W-1:0] scr_payload;
  logic [SCR_TAP_B-1:0] scr_state;
  logic                 s_accept;

  // Ready depends only on M_READY and the hold flag, never on S_VALID.
  assign S_READY  = !hold_valid_q || M_READY;
  assign s_accept = S_VALID && S_READY;

  // An empty hold means the gearbox gets an idle block instead.
  assign src_block = hold_valid_q ? hold_q : P66B_IDLE;

  p66b_scramble_comb u_scramble (
    .state_i   (state_q),
    .payload_i (src_block[BLOCK_W-1:2]),
    .scr_o     (scr_payload),
    .state_o   (scr_state)
  );

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    state_d      = state_q;
    m_data_d     = m_data_q;
    idle_d       = 1'b0;
    err_d        = s_accept && !sync_hdr_valid(S_DATA[1:0]);

    if (M_READY) begin
      // Word consumed: load the next one and refill the hold in the same edge.
      if (OPT_SCRAMBLE) begin
        m_data_d = {scr_payload, src_block[1:0]};
        state_d  = scr_state;
      end else begin
        m_data_d = src_block;
      end
      idle_d       = !hold_valid_q;
      hold_valid_d = S_VALID;
      if (S_VALID) begin
        hold_d = S_DATA;
      end
    end else if (!hold_valid_q && S_VALID) begin
      hold_d       = S_DATA;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      state_q      <= SEED;
      m_data_q     <= P66B_IDLE;
      idle_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      state_q      <= state_d;
      m_data_q     <= m_data_d;
      idle_q       <= idle_d;
      err_q        <= err_d;
    end
  end

  assign M_DATA = m_data_q;
  assign o_idle = idle_q;
  assign o_err  = err_q;

endmodule

// File: tb/tb_p66b_tx_scrambler.sv
module tb_p66b_tx_scrambler;
  import p66b_pkg::*;

  localparam logic [57:0] SEED_TB = 58'h0;

  logic        i_clk;
  logic        i_reset;
  logic        s_valid;
  logic        s_ready;
  logic [65:0] s_data;
  logic        m_ready;
  logic [65:0] m_data;
  logic        o_idle;
  logic        o_err;
  logic        b_s_ready;
  logic [65:0] b_m_data;
  logic        b_idle;
  logic        b_err;

  p66b_tx_scrambler #(.OPT_SCRAMBLE(1'b1), .SEED(SEED_TB)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .S_VALID (s_valid),
    .S_READY (s_ready),
    .S_DATA  (s_data),
    .M_READY (m_ready),
    .M_DATA  (m_data),
    .o_idle  (o_idle),
    .o_err   (o_err)
  );

  p66b_tx_scrambler #(.OPT_SCRAMBLE(1'b0), .SEED(SEED_TB)) dut_bypass (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .S_VALID (s_valid),
    .S_READY (b_s_ready),
    .S_DATA  (s_data),
    .M_READY (m_ready),
    .M_DATA  (b_m_data),
    .o_idle  (b_idle),
    .o_err   (b_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        sv;
    logic [65:0] sd;
    logic        mr;
    logic        rdy;
    logic        idle;
    logic        err;
    logic        use_data;
    logic [65:0] data;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [65:0] m_m, hold_m;
  logic        hv_m, idle_m, err_m;
  logic [57:0] st_m;

  // Bit-serial scrambler: sr[57] is the most recent scrambled bit.
  function automatic logic [121:0] scr_ref(input logic [57:0] st, input logic [63:0] p);
    logic [57:0] sr;
    logic [63:0] o;
    logic        b;
    sr = st;
    for (int i = 0; i < 64; i++) begin
      b    = p[i] ^ sr[19] ^ sr[0];
      o[i] = b;
      sr   = {b, sr[57:1]};
    end
    return {sr, o};
  endfunction

  function automatic logic [63:0] descr_ref(input logic [57:0] st, input logic [63:0] y);
    logic [57:0] sr;
    logic [63:0] o;
    sr = st;
    for (int i = 0; i < 64; i++) begin
      o[i] = y[i] ^ sr[19] ^ sr[0];
      sr   = {y[i], sr[57:1]};
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic sv, input logic [65:0] sd, input logic mr,
                            input logic rst);
    logic [121:0] r;
    logic [65:0]  src;
    if (rst) begin
      m_m    = P66B_IDLE;
      hv_m   = 1'b0;
      st_m   = SEED_TB;
      idle_m = 1'b0;
      err_m  = 1'b0;
    end else begin
      err_m = sv && (!hv_m || mr) && (sd[1:0] == 2'b00 || sd[1:0] == 2'b11);
      if (mr) begin
        src    = hv_m ? hold_m : P66B_IDLE;
        r      = scr_ref(st_m, src[65:2]);
        m_m    = {r[63:0], src[1:0]};
        st_m   = r[121:64];
        idle_m = !hv_m;
        hv_m   = sv;
        if (sv) hold_m = sd;
      end else begin
        idle_m = 1'b0;
        if (!hv_m && sv) begin
          hold_m = sd;
          hv_m   = 1'b1;
        end
      end
    end
  endtask

  // Drive, check ready before the edge, clock, then check registered outputs.
  task automatic apply(input vec_t v, input bit from_model);
    logic exp_rdy;
    s_valid = v.sv;
    s_data  = v.sd;
    m_ready = v.mr;
    #1;
    exp_rdy = from_model ? (!hv_m || v.mr) : v.rdy;
    chk("s_ready", {65'h0, s_ready}, {65'h0, exp_rdy});
    @(posedge i_clk);
    model_step(v.sv, v.sd, v.mr, 1'b0);
    #1;
    chk("m_data", m_data, (from_model || !v.use_data) ? m_m : v.data);
    chk("o_idle", {65'h0, o_idle}, {65'h0, from_model ? idle_m : v.idle});
    chk("o_err", {65'h0, o_err}, {65'h0, from_model ? err_m : v.err});
  endtask

  vec_t        tbl[14];
  vec_t        rst_tbl[2];
  vec_t        v;
  logic [65:0] blk_a, blk_b, blk_bad;
  logic [63:0] cnt, exp_pl, pl;
  logic [63:0] prev;
  logic        acc;
  int          idles;

  initial begin
    blk_a   = {64'hA5A5_0000_1111_2222, 2'b10};
    blk_b   = {64'h0123_4567_89AB_CDEF, 2'b10};
    blk_bad = {64'hDEAD_BEEF_0123_4567, 2'b11};

    //            sv    sd                            mr    rdy   idle  err   use   data
    tbl[0]  = '{1'b1, {64'h1, 2'b10},               1'b0, 1'b1, 1'b0, 1'b0, 1'b1, P66B_IDLE};
    tbl[1]  = '{1'b0, 66'h0,                        1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                {64'h0400_0080_0000_0001, 2'b10}};
    tbl[2]  = '{1'b0, 66'h0,                        1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                {64'h7830_0F00_0000_401E, 2'b01}};
    tbl[3]  = '{1'b1, blk_bad,                      1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 66'h0};
    tbl[4]  = '{1'b0, 66'h0,                        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 66'h0};
    tbl[5]  = '{1'b0, 66'h0,                        1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 66'h0};
    tbl[6]  = '{1'b1, blk_a,                        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 66'h0};
    tbl[7]  = '{1'b1, blk_b,                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 66'h0};
    tbl[8]  = '{1'b1, blk_b,                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 66'h0};
    tbl[9]  = '{1'b1, blk_b,                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 66'h0};
    tbl[10] = '{1'b1, blk_b,                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 66'h0};
    tbl[11] = '{1'b1, blk_b,                        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 66'h0};
    tbl[12] = '{1'b0, 66'h0,                        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 66'h0};
    tbl[13] = '{1'b0, 66'h0,                        1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 66'h0};

    rst_tbl[0] = '{1'b0, 66'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, P66B_IDLE};
    rst_tbl[1] = '{1'b0, 66'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                   {64'h7800_0F00_0000_001E, 2'b01}};

    hold_m  = '0;
    i_reset = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    model_step(1'b0, 66'h0, 1'b1, 1'b1);
    #1;
    i_reset = 1'b0;
    chk("reset m_data", m_data, P66B_IDLE);
    chk("reset o_idle", {65'h0, o_idle}, 66'h0);
    chk("reset o_err", {65'h0, o_err}, 66'h0);

    // Hand-computed vectors: first block, tap propagation, bad header, stall.
    for (int i = 0; i < 14; i++) apply(tbl[i], 1'b0);

    // Idle run: bypass instance must emit the idle block unchanged.
    for (int i = 0; i < 4; i++) begin
      v = '{1'b0, 66'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 66'h0};
      apply(v, 1'b1);
      chk("bypass m_data", b_m_data, P66B_IDLE);
      chk("bypass o_idle", {65'h0, b_idle}, 66'h1);
      chk("bypass s_ready", {65'h0, b_s_ready}, 66'h1);
      chk("bypass o_err", {65'h0, b_err}, 66'h0);
    end

    // Streaming with ready low 1 in 33: order checked by descrambling M_DATA.
    cnt    = '0;
    exp_pl = '0;
    idles  = 0;
    prev   = m_data[65:2];
    for (int c = 0; c < 99; c++) begin
      v   = '{1'b1, {cnt, 2'b10}, ((c % 33) != 32), 1'b0, 1'b0, 1'b0, 1'b0, 66'h0};
      acc = !hv_m || v.mr;
      apply(v, 1'b1);
      if (acc) cnt++;
      if (v.mr) begin
        if (o_idle) begin
          idles++;
        end else begin
          pl = descr_ref(prev[63:6], m_data[65:2]);
          chk("order payload", {2'b00, pl}, {2'b00, exp_pl});
          chk("order header", {64'h0, m_data[1:0]}, {64'h0, 2'b10});
          exp_pl++;
        end
        prev = m_data[65:2];
      end
    end
    chk("stream idles", 66'(idles), 66'd1);

    // Reset with a block held: held block dropped, sequence restarts from SEED.
    v = '{1'b1, blk_a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 66'h0};
    apply(v, 1'b1);
    i_reset = 1'b1;
    s_valid = 1'b1;
    s_data  = blk_b;
    m_ready = 1'b1;
    @(posedge i_clk);
    model_step(1'b1, blk_b, 1'b1, 1'b1);
    #1;
    i_reset = 1'b0;
    chk("midreset m_data", m_data, P66B_IDLE);
    chk("midreset o_idle", {65'h0, o_idle}, 66'h0);
    for (int i = 0; i < 2; i++) apply(rst_tbl[i], 1'b0);
    for (int i = 0; i < 6; i++) begin
      v = '{(i % 2) == 0, {64'hC0DE_0000_0000_0000 | 64'(i), 2'b10}, 1'b1,
            1'b0, 1'b0, 1'b0, 1'b0, 66'h0};
      apply(v, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
